// File: rtl/mux16_arbiter.sv
// rtl/mux16_arbiter.sv - two-source valid/ready arbiter sharing one mux16 datapath
// Burst-limited arbitration feeding a single-entry output register.

module mux16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        sel,
  output logic [15:0] out
);
  assign out = sel ? y : x;
endmodule

module mux16_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        x_valid,
  input  logic [15:0] x_data,
  output logic        x_ready,
  input  logic        y_valid,
  input  logic [15:0] y_data,
  output logic        y_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_src,
  input  logic        out_ready
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_t      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic        src_q, src_d;
  logic        last_src_q, last_src_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;

  logic        grant;
  logic        slot_free;
  logic        xfer;
  logic [15:0] mux_out;

  mux16 u_mux16 (
    .x   (x_data),
    .y   (y_data),
    .sel (grant),
    .out (mux_out)
  );

  // The burst limit only matters under contention; a lone requester always wins.
  always_comb begin
    grant = last_src_q;
    unique case ({x_valid, y_valid})
      2'b10:   grant = 1'b0;
      2'b01:   grant = 1'b1;
      2'b11:   grant = (burst_cnt_q < MAX_B) ? last_src_q : !last_src_q;
      default: grant = last_src_q;
    endcase
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign slot_free = !out_valid || out_ready;
  assign x_ready   = rst_n && slot_free && !grant;
  assign y_ready   = rst_n && slot_free && grant;
  assign xfer      = (x_valid && x_ready) || (y_valid && y_ready);

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    src_d       = src_q;
    last_src_d  = last_src_q;
    burst_cnt_d = burst_cnt_q;
    if (xfer) begin
      state_d    = FULL;
      data_d     = mux_out;
      src_d      = grant;
      last_src_d = grant;
      if (grant == last_src_q) begin
        burst_cnt_d = (burst_cnt_q >= MAX_B) ? MAX_B : burst_cnt_q + 4'd1;
      end else begin
        burst_cnt_d = 4'd1;
      end
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      data_q      <= 16'h0000;
      src_q       <= 1'b0;
      last_src_q  <= 1'b0;
      burst_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      src_q       <= src_d;
      last_src_q  <= last_src_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
endmodule

// File: tb/tb_mux16_arbiter.sv
// tb/tb_mux16_arbiter.sv - randomized self-checking bench for mux16_arbiter
// Two instances (MAX_BURST 4 and 1) share stimulus; each has its own reference model.

module tb_mux16_arbiter;
  logic        clk;
  logic        rst_n;
  logic        x_valid, y_valid, out_ready;
  logic [15:0] x_data, y_data;

  logic [1:0]  x_ready_w, y_ready_w, out_valid_w, out_src_w;
  logic [15:0] out_data_w [2];

  mux16_arbiter #(.MAX_BURST(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready_w[0]),
    .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready_w[0]),
    .out_valid(out_valid_w[0]), .out_data(out_data_w[0]), .out_src(out_src_w[0]),
    .out_ready(out_ready)
  );

  mux16_arbiter #(.MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready_w[1]),
    .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready_w[1]),
    .out_valid(out_valid_w[1]), .out_data(out_data_w[1]), .out_src(out_src_w[1]),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: held word plus the current winning streak of each instance.
  int          mb [2] = '{4, 1};
  bit          m_valid [2];
  logic [15:0] m_data [2];
  bit          m_src [2];
  bit          m_last [2];
  int          m_run [2];
  bit          acc_x0, acc_y0;
  int          rdy_sum [2];

  function automatic bit model_grant(int i, bit xv, bit yv);
    if (xv && !yv) return 1'b0;
    if (yv && !xv) return 1'b1;
    if (xv && yv)  return (m_run[i] < mb[i]) ? m_last[i] : !m_last[i];
    return m_last[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0; m_data[i] = 16'h0000; m_src[i] = 0;
      m_last[i] = 0; m_run[i] = 0;
    end
  endtask

  task automatic reset_checks(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_x_ready%0d", tag, i), x_ready_w[i], 0);
      check($sformatf("%s_y_ready%0d", tag, i), y_ready_w[i], 0);
      check($sformatf("%s_out_valid%0d", tag, i), out_valid_w[i], 0);
      check($sformatf("%s_out_data%0d", tag, i), out_data_w[i], 16'h0000);
      check($sformatf("%s_out_src%0d", tag, i), out_src_w[i], 0);
    end
  endtask

  task automatic step(input bit xv, input logic [15:0] xd, input bit yv,
                      input logic [15:0] yd, input bit ordy);
    bit g [2];
    bit sf [2];
    bit xf [2];
    x_valid = xv; x_data = xd; y_valid = yv; y_data = yd; out_ready = ordy;
    #1;
    for (int i = 0; i < 2; i++) begin
      g[i]  = model_grant(i, xv, yv);
      sf[i] = !m_valid[i] || ordy;
      xf[i] = sf[i] && (g[i] ? yv : xv);
      check($sformatf("x_ready%0d", i), x_ready_w[i], sf[i] && !g[i]);
      check($sformatf("y_ready%0d", i), y_ready_w[i], sf[i] && g[i]);
      rdy_sum[i] = int'(x_ready_w[i]) + int'(y_ready_w[i]);
    end
    acc_x0 = xf[0] && !g[0];
    acc_y0 = xf[0] && g[0];
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (xf[i]) begin
        m_valid[i] = 1;
        m_data[i]  = g[i] ? yd : xd;
        m_src[i]   = g[i];
        m_run[i]   = (g[i] == m_last[i]) ? m_run[i] + 1 : 1;
        m_last[i]  = g[i];
      end else if (m_valid[i] && ordy) begin
        m_valid[i] = 0;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("out_valid%0d", i), out_valid_w[i], m_valid[i]);
      check($sformatf("out_src%0d", i), out_src_w[i], m_src[i]);
      check($sformatf("out_data%0d", i), out_data_w[i], m_data[i]);
    end
  endtask

  task automatic full_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit          src_a [9];
    bit          src_b [9];
    bit          pend_x, pend_y;
    bit          rxv, ryv;
    logic [15:0] rxd, ryd, w;
    bit          g0;

    rst_n = 1'b0; x_valid = 1; y_valid = 1; out_ready = 1;
    x_data = 16'h1234; y_data = 16'h4321;
    model_reset();
    #3 reset_checks("reset_async");
    repeat (2) @(posedge clk);
    #1 reset_checks("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    // single source
    step(1, 16'h9112, 0, 16'h0000, 1);
    check("single_data", out_data_w[0], 16'h9112);
    check("single_src", out_src_w[0], 0);
    for (int k = 0; k < 10; k++) begin
      w = 16'($urandom);
      step(1, w, 0, 16'h0000, 1);
      check("burst_x_acc", acc_x0, 1);
      check("burst_x_data", out_data_w[0], w);
    end

    // contention from reset
    full_reset();
    for (int k = 0; k < 9; k++) begin
      step(1, 16'h0000, 1, 16'h5555, 1);
      src_a[k] = out_src_w[0];
      src_b[k] = out_src_w[1];
      check("one_ready4", rdy_sum[0], 1);
      check("one_ready1", rdy_sum[1], 1);
    end
    for (int k = 0; k < 9; k++) begin
      check($sformatf("tie4_src%0d", k), src_a[k], (k >= 4 && k < 8) ? 1 : 0);
      check($sformatf("tie1_src%0d", k), src_b[k], k % 2);
    end

    // backpressure
    step(0, 16'h0000, 1, 16'h5555, 1);
    for (int k = 0; k < 3; k++) begin
      step(1, 16'hFFFF, 0, 16'h0000, 0);
      check("bp_hold", out_data_w[0], 16'h5555);
      check("bp_ready", rdy_sum[0], 0);
    end
    step(1, 16'hFFFF, 0, 16'h0000, 1);
    check("bp_reload_valid", out_valid_w[0], 1);
    check("bp_reload_data", out_data_w[0], 16'hFFFF);

    // reset mid-burst after two Y transfers
    full_reset();
    for (int k = 0; k < 6; k++) step(1, 16'h0A0A, 1, 16'h0B0B, 1);
    check("midburst_src", out_src_w[0], 1);
    full_reset();
    step(1, 16'h0C0C, 1, 16'h0D0D, 1);
    check("post_rst_grant4", out_src_w[0], 0);
    check("post_rst_grant1", out_src_w[1], 0);

    // randomized traffic; requesters hold offers until instance 0 accepts
    pend_x = 0; pend_y = 0; rxv = 0; ryv = 0; rxd = 0; ryd = 0;
    for (int k = 0; k < 400; k++) begin
      if (!pend_x) begin rxv = ($urandom_range(0, 3) != 0); rxd = 16'($urandom); end
      if (!pend_y) begin ryv = ($urandom_range(0, 3) != 0); ryd = 16'($urandom); end
      g0 = model_grant(0, rxv, ryv);
      step(rxv, rxd, ryv, ryd, ($urandom_range(0, 3) != 0));
      pend_x = rxv && !acc_x0;
      pend_y = ryv && !acc_y0;
      if (acc_x0 || acc_y0) check("rand_src", out_src_w[0], g0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
